// File: rtl/coffee_pkg.sv
// rtl/coffee_pkg.sv - shared types and constants for the coffee machine datapath
//
// Purpose: unit type shared by the coin counter, subtractor and change dispenser,
//          the dispenser state encoding and the value of each coin in units of 100.
// Ports:   none (package).
package coffee_pkg;

  // Money in units of 100 (0..15 = 0..1500).
  typedef logic [3:0] coin_units_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    PULSE  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } dispenser_state_t;

  localparam coin_units_t COIN_500_UNITS = 4'd5;
  localparam coin_units_t COIN_100_UNITS = 4'd1;

endpackage

// File: rtl/cycle_countdown_module.sv
// rtl/cycle_countdown_module.sv - reloadable 8-bit down counter timing pulse and gap phases
//
// Purpose: loaded with a phase length on entry to a timed phase, counts down to 1 and
//          flags the last cycle of that phase.
// Ports:   clock, reset (async active-low), load, load_value[7:0], enable -> expired.
module cycle_countdown_module (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       enable,
  output logic       expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q > 8'd1)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A phase loaded with N lasts N cycles: the final one is the cycle showing 1.
  assign expired = (count_q == 8'd1);

endmodule

// File: rtl/change_dispenser_module.sv
// rtl/change_dispenser_module.sv - greedy coin payout of a change amount as eject pulses
//
// Purpose: turns a change total (units of 100) into 500 then 100 coin eject pulses,
//          with a busy/done handshake for the top-level FSM.
// Ports:   clock, reset (async active-low), start, change[3:0], hopper_500_empty
//          -> eject_500, eject_100, busy, done, remaining[3:0].
module change_dispenser_module
  import coffee_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  coin_units_t change,
  input  logic        hopper_500_empty,
  output logic        eject_500,
  output logic        eject_100,
  output logic        busy,
  output logic        done,
  output coin_units_t remaining
);

  dispenser_state_t state_q, state_d;
  coin_units_t      remaining_q, remaining_d;
  logic             coin_sel_500_q, coin_sel_500_d;
  logic             eject_500_q, eject_500_d;
  logic             eject_100_q, eject_100_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic       cnt_load;
  logic [7:0] cnt_value;
  logic       cnt_enable;
  logic       cnt_expired;

  cycle_countdown_module u_countdown (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .enable     (cnt_enable),
    .expired    (cnt_expired)
  );

  assign cnt_enable = (state_q == PULSE) || (state_q == GAP);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      remaining_q    <= '0;
      coin_sel_500_q <= 1'b0;
      eject_500_q    <= 1'b0;
      eject_100_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      coin_sel_500_q <= coin_sel_500_d;
      eject_500_q    <= eject_500_d;
      eject_100_q    <= eject_100_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    coin_sel_500_d = coin_sel_500_q;
    cnt_load       = 1'b0;
    cnt_value      = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = change;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end else begin
          // The coin choice is frozen here, so hopper changes mid-pulse do not matter.
          coin_sel_500_d = (remaining_q >= COIN_500_UNITS) && !hopper_500_empty;
          state_d        = PULSE;
          cnt_load       = 1'b1;
          cnt_value      = 8'(PULSE_CYCLES);
        end
      end
      PULSE: begin
        if (cnt_expired) begin
          remaining_d = remaining_q - (coin_sel_500_q ? COIN_500_UNITS : COIN_100_UNITS);
          state_d     = GAP;
          cnt_load    = 1'b1;
          cnt_value   = 8'(GAP_CYCLES);
        end
      end
      GAP: begin
        if (cnt_expired) begin
          state_d = SELECT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so the registered copies line up with it.
  always_comb begin
    eject_500_d = (state_d == PULSE) && coin_sel_500_d;
    eject_100_d = (state_d == PULSE) && !coin_sel_500_d;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  assign eject_500 = eject_500_q;
  assign eject_100 = eject_100_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser_module.sv
// tb/tb_change_dispenser_module.sv - self-checking bench for change_dispenser_module
module tb_change_dispenser_module;

  localparam int PULSE = 2;
  localparam int GAP   = 1;
  localparam int SLOT  = 1 + PULSE + GAP;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] change;
  logic       hopper_500_empty;
  logic       eject_500;
  logic       eject_100;
  logic       busy;
  logic       done;
  logic [3:0] remaining;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int coin;
    int rem;
  } coin_t;

  coin_t exp_q[$];
  int    plan_q[$];
  coin_t cur;
  int    width;
  logic  prev_500;
  logic  prev_100;

  change_dispenser_module #(
    .PULSE_CYCLES (PULSE),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .change           (change),
    .hopper_500_empty (hopper_500_empty),
    .eject_500        (eject_500),
    .eject_100        (eject_100),
    .busy             (busy),
    .done             (done),
    .remaining        (remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Scoreboard side: every eject rising edge pops one expected coin.
  initial begin
    prev_500 = 1'b0;
    prev_100 = 1'b0;
    width    = 0;
    cur      = '{0, 0};
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_500 = 1'b0;
        prev_100 = 1'b0;
        width    = 0;
      end else begin
        check("eject_exclusive", int'(eject_500 & eject_100), 0);
        if ((eject_500 && !prev_500) || (eject_100 && !prev_100)) begin
          if (exp_q.size() == 0) begin
            check("coin_unexpected", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            check("coin_type", eject_500 ? 500 : 100, cur.coin);
          end
          width = 0;
        end
        if (eject_500 || eject_100) begin
          width++;
        end else if (prev_500 || prev_100) begin
          check("pulse_width", width, PULSE);
          check("remaining_after_coin", int'(remaining), cur.rem);
        end
        prev_500 = eject_500;
        prev_100 = eject_100;
      end
    end
  end

  task automatic greedy(input int ch, input bit empty);
    int r;
    r = ch;
    while (r >= 5 && !empty) begin
      plan_q.push_back(500);
      r -= 5;
    end
    while (r > 0) begin
      plan_q.push_back(100);
      r--;
    end
  endtask

  // Drives one payout of plan_q and checks each cycle against a timing model.
  task automatic run_payout(input int ch, input int hop_cyc, input int restart_cyc);
    int   n, lat, r, cyc, k, slot, off, e500, e100, er;
    logic seen_done;
    n   = plan_q.size();
    lat = 2 + n * SLOT;
    r   = ch;
    foreach (plan_q[i]) begin
      r -= (plan_q[i] == 500) ? 5 : 1;
      exp_q.push_back('{plan_q[i], r});
    end
    @(negedge clock);
    change = 4'(ch);
    start  = 1'b1;
    @(negedge clock);
    start     = 1'b0;
    change    = 4'(ch + 1);
    cyc       = 1;
    seen_done = 1'b0;
    while (!seen_done && cyc <= lat + 5) begin
      if (cyc == hop_cyc) hopper_500_empty = 1'b1;
      if (cyc == restart_cyc) begin
        start  = 1'b1;
        change = 4'd4;
      end
      if (cyc == restart_cyc + 1) start = 1'b0;
      k    = cyc - 1;
      slot = k / SLOT;
      off  = k % SLOT;
      e500 = 0;
      e100 = 0;
      if (slot < n && off >= 1 && off <= PULSE) begin
        if (plan_q[slot] == 500) e500 = 1;
        else e100 = 1;
      end
      er = ch;
      for (int j = 0; j < n; j++) begin
        if (k >= j * SLOT + PULSE + 1) er -= (plan_q[j] == 500) ? 5 : 1;
      end
      check("eject_500_t", int'(eject_500), e500);
      check("eject_100_t", int'(eject_100), e100);
      check("busy_t", int'(busy), 1);
      check("remaining_t", int'(remaining), er);
      if (done) begin
        check("done_latency", cyc, lat);
        seen_done = 1'b1;
      end else begin
        @(negedge clock);
        cyc++;
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    @(negedge clock);
    check("busy_after", int'(busy), 0);
    check("done_single", int'(done), 0);
    check("coins_left", exp_q.size(), 0);
    plan_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset            = 1'b0;
    start            = 1'b0;
    change           = 4'd0;
    hopper_500_empty = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_eject_500", int'(eject_500), 0);
    check("rst_eject_100", int'(eject_100), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_remaining", int'(remaining), 0);
    reset = 1'b1;
    @(negedge clock);

    greedy(7, 1'b0);
    run_payout(7, -1, -1);

    greedy(0, 1'b0);
    run_payout(0, -1, -1);

    hopper_500_empty = 1'b1;
    greedy(10, 1'b1);
    run_payout(10, -1, -1);
    hopper_500_empty = 1'b0;

    plan_q.push_back(500);
    plan_q.push_back(500);
    repeat (5) plan_q.push_back(100);
    run_payout(15, 6, -1);
    hopper_500_empty = 1'b0;

    // Reset in the middle of the first 500 pulse.
    exp_q.push_back('{500, 4});
    @(negedge clock);
    change = 4'd9;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("rst_mid_pre_eject", int'(eject_500), 1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_eject_500", int'(eject_500), 0);
    check("rst_mid_eject_100", int'(eject_100), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_remaining", int'(remaining), 0);
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    greedy(3, 1'b0);
    run_payout(3, -1, -1);

    greedy(6, 1'b0);
    run_payout(6, -1, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser_module.md
Name: change_dispenser_module

Overview:
- Pays out the change computed by the coffee-selection subtractor as discrete coin-ejection pulses to the 500 and 100 coin hoppers.
- It is the output-side counterpart of the coin counter: the counter turns coin_100/coin_500 pulses into a unit total, and this block turns a unit total back into coin pulses.
- Greedy payout: 500 coins first, then 100 coins. A busy/done handshake goes to the top-level FSM.

Parameters:
- PULSE_CYCLES, 2, clock cycles each eject pulse stays high (range 1..255).
- GAP_CYCLES, 1, clock cycles low between consecutive pulses (range 1..255).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to pay out; sampled only in IDLE.
- change  input  4  change amount in units of 100 (0..15 = 0..1500); sampled on the accepted start edge.
- hopper_500_empty  input  1  high when the 500 hopper cannot pay; sampled in SELECT.
- eject_500  output  1  eject one 500 coin while high.
- eject_100  output  1  eject one 100 coin while high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when payout completes.
- remaining  output  4  units of 100 still to be paid.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, remaining=0, eject_500=0, eject_100=0, busy=0, done=0, internal cycle counter=0. Applies immediately, including mid-pulse; no partial coin is completed.
- All outputs are registered and decoded from state.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE: on an edge with start=1, latch remaining<=change and go to SELECT. start in any other state is ignored, and change is not re-sampled.
- SELECT (exactly 1 cycle):
  - remaining==0 -> DONE.
  - remaining>=5 and hopper_500_empty=0 -> coin_sel=500, go to PULSE.
  - otherwise -> coin_sel=100, go to PULSE. With the 500 hopper empty, 500-worth is paid as five 100 coins.
- PULSE: eject_500 or eject_100 (per coin_sel) held high for exactly PULSE_CYCLES cycles. Both ejects are never high together. On the exit edge, remaining decrements by 5 or 1, then go to GAP.
- GAP: both ejects low for exactly GAP_CYCLES cycles, then SELECT.
- DONE: done=1 for exactly one cycle, busy still 1; next state IDLE.
- Latency from the accepted start edge to the done cycle: 2 + coins*(1+PULSE_CYCLES+GAP_CYCLES) cycles. With change=0 it is 2 (SELECT then DONE, no pulses).
- Arithmetic:
  - remaining is unsigned 4-bit and never underflows; 500 is chosen only when remaining>=5.
  - The cycle counter width is 8 bits. It reloads on entry to PULSE and GAP and counts down to 1.
- hopper_500_empty changes mid-pulse have no effect on the coin in flight.
- start held high continuously: a new payout begins on the first IDLE edge after DONE.

Decomposition:
- Shared package coffee_pkg:
  - state enum dispenser_state_t {IDLE, SELECT, PULSE, GAP, DONE}.
  - constants COIN_500_UNITS=5 and COIN_100_UNITS=1.
  - typedef coin_units_t = logic [3:0], shared with the coin counter and subtractor.
- One sub-module: cycle_countdown_module.
  - Inputs: load, load value, enable.
  - Output: expired flag.
  - Instantiated once and used for both PULSE and GAP timing.

Test Plan:
- change=7, defaults, start 1 cycle -> eject_500 high cycles 2-3, eject_100 high cycles 6-7 and 10-11 (cycle 0 = start edge); remaining 7->2->1->0; done pulse at cycle 14; busy cycles 1-14.
- change=0, start -> no eject pulses; done at cycle 2; busy cycles 1-2; remaining stays 0.
- change=10, hopper_500_empty=1 throughout -> ten eject_100 pulses, zero eject_500; done at cycle 2+10*4=42.
- change=15, hopper_500_empty rises during the second 500 pulse -> that pulse completes; payout is 500,500 then five 100 pulses; remaining ends 0; done asserted once.
- change=9, reset driven low mid-PULSE of the first coin -> eject_500, busy, remaining go 0 immediately (asynchronous, before the next edge). After release, start with change=3 -> three 100 pulses, normal done.
- start re-asserted with change=4 while busy during a change=6 payout -> ignored; total pulses are one 500 plus one 100; remaining never loads 4.
